// File: rtl/cv32e40p_pkg.sv
// Shared core package: FIFO sizing constants, error-flag struct and threshold helpers.
package cv32e40p_pkg;

  localparam int unsigned FIFO_MAX_DEPTH = 256;

  typedef struct packed {
    logic ovf;
    logic unf;
  } fifo_err_t;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic fifo_cnt_ge(input int unsigned cnt, input int unsigned th);
    return cnt >= th;
  endfunction

  function automatic logic fifo_cnt_le(input int unsigned cnt, input int unsigned th);
    return cnt <= th;
  endfunction

endpackage

// File: rtl/cv32e40p_fifo_ptr.sv
// Pointer that wraps from DEPTH-1 back to 0; clear beats load beats increment.
module cv32e40p_fifo_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o,
  output logic [AW-1:0] ptr_inc_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q, ptr_d;

  assign ptr_inc_o = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign ptr_o     = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)       ptr_d = '0;
    else if (load_i) ptr_d = load_val_i;
    else if (inc_i)  ptr_d = ptr_inc_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cv32e40p_fifo_th.sv
// Synchronous FIFO with any depth, almost-full/empty thresholds, sticky
// overflow/underflow flags, flush / flush-but-first and optional fall-through.
module cv32e40p_fifo_th
  import cv32e40p_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = fifo_addr_w(DEPTH),
  parameter int unsigned AF_THRESH    = DEPTH - 1,
  parameter int unsigned AE_THRESH    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  flush_but_first_i,
  input  logic                  testmode_i,
  input  logic                  clear_err_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_DEPTH:0]   cnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned CW = ADDR_DEPTH + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  fifo_err_t             err_q, err_d;
  logic [ADDR_DEPTH-1:0] rptr, rptr_inc, wptr, wptr_inc;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      mem_we;

  logic cnt_zero, flush_any, ft_active, bypass, push_acc, pop_acc;
  logic ptr_clr, wptr_load;
  logic unused_testmode;

  assign unused_testmode = testmode_i;

  assign cnt_zero  = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign flush_any = flush_i | flush_but_first_i;

  // Fall-through: an empty FIFO presents the incoming word directly.
  assign ft_active = FALL_THROUGH & cnt_zero & push_i;
  assign bypass    = ft_active & pop_i;

  assign empty_o = cnt_zero & ~ft_active;
  assign data_o  = ft_active ? data_i : mem_q[rptr];

  assign push_acc = push_i & ~full_o & ~bypass & ~flush_any;
  assign pop_acc  = pop_i & ~cnt_zero & ~flush_any;

  assign ptr_clr   = flush_i | (flush_but_first_i & cnt_zero);
  assign wptr_load = flush_but_first_i & ~cnt_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (ptr_clr)        cnt_d = '0;
    else if (wptr_load) cnt_d = CW'(1);
    else                cnt_d = cnt_q + CW'(push_acc) - CW'(pop_acc);
  end

  // Set wins over clear; no errors are raised during flush cycles.
  always_comb begin
    err_d.ovf = (push_i & full_o & ~flush_any) | (err_q.ovf & ~clear_err_i);
    err_d.unf = (pop_i & empty_o & ~flush_any) | (err_q.unf & ~clear_err_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign overflow_o     = err_q.ovf;
  assign underflow_o    = err_q.unf;
  assign almost_full_o  = fifo_cnt_ge(32'(cnt_q), AF_THRESH);
  assign almost_empty_o = fifo_cnt_le(32'(cnt_q), AE_THRESH);

  cv32e40p_fifo_ptr #(.DEPTH(DEPTH), .AW(ADDR_DEPTH)) u_rptr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (ptr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (pop_acc),
    .ptr_o      (rptr),
    .ptr_inc_o  (rptr_inc)
  );

  cv32e40p_fifo_ptr #(.DEPTH(DEPTH), .AW(ADDR_DEPTH)) u_wptr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (ptr_clr),
    .load_i     (wptr_load),
    .load_val_i (rptr_inc),
    .inc_i      (push_acc),
    .ptr_o      (wptr),
    .ptr_inc_o  (wptr_inc)
  );

  logic [ADDR_DEPTH-1:0] unused_wptr_inc;
  assign unused_wptr_inc = wptr_inc;

  // Per-entry write enable; this is also the clock-gate enable of each entry.
  always_comb begin
    mem_we = '0;
    if (push_acc) mem_we[wptr] = 1'b1;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         mem_q[gi] <= '0;
      else if (mem_we[gi]) mem_q[gi] <= data_i;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fifo_th.sv
// Directed bench: queue model checks the FIFO every cycle, plus literal spot checks.
module tb_cv32e40p_fifo_th;

  localparam int DEPTH = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, fbf = 1'b0, tmode = 1'b0, clr = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic [7:0] din = 8'h00;

  logic       full, afull, empty, aempty, ovf, unf;
  logic [7:0] dout;
  logic [3:0] cnt;
  logic       full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
  logic [7:0] dout_f;
  logic [3:0] cnt_f;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cv32e40p_fifo_th #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(DEPTH),
                     .AF_THRESH(4), .AE_THRESH(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_but_first_i(fbf),
    .testmode_i(tmode), .clear_err_i(clr), .push_i(push), .data_i(din),
    .full_o(full), .almost_full_o(afull), .pop_i(pop), .data_o(dout),
    .empty_o(empty), .almost_empty_o(aempty), .cnt_o(cnt),
    .overflow_o(ovf), .underflow_o(unf)
  );

  cv32e40p_fifo_th #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(DEPTH),
                     .AF_THRESH(4), .AE_THRESH(1)) dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_but_first_i(fbf),
    .testmode_i(tmode), .clear_err_i(clr), .push_i(push), .data_i(din),
    .full_o(full_f), .almost_full_o(afull_f), .pop_i(pop), .data_o(dout_f),
    .empty_o(empty_f), .almost_empty_o(aempty_f), .cnt_o(cnt_f),
    .overflow_o(ovf_f), .underflow_o(unf_f)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the non-fall-through FIFO.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit po_ok, pu_ok, o_set, u_set;
      o_set = 1'b0; u_set = 1'b0;
      if (flush) begin
        mq.delete();
      end else if (fbf) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else begin
        po_ok = pop && (mq.size() > 0);
        pu_ok = push && (mq.size() < DEPTH);
        o_set = push && (mq.size() == DEPTH);
        u_set = pop && (mq.size() == 0);
        if (po_ok) void'(mq.pop_front());
        if (pu_ok) mq.push_back(din);
      end
      m_ovf = o_set | (m_ovf & ~clr);
      m_unf = u_set | (m_unf & ~clr);
    end
  end

  always @(negedge clk) begin
    chk("m_cnt",    32'(cnt),    32'(mq.size()));
    chk("m_full",   32'(full),   32'(mq.size() == DEPTH));
    chk("m_empty",  32'(empty),  32'(mq.size() == 0));
    chk("m_afull",  32'(afull),  32'(mq.size() >= 4));
    chk("m_aempty", 32'(aempty), 32'(mq.size() <= 1));
    chk("m_ovf",    32'(ovf),    32'(m_ovf));
    chk("m_unf",    32'(unf),    32'(m_unf));
    if (mq.size() > 0) chk("m_data", 32'(dout), 32'(mq[0]));
  end

  task automatic drive(input logic pu, input logic po, input logic [7:0] d,
                       input logic fl, input logic fb, input logic cl);
    push = pu; pop = po; din = d; flush = fl; fbf = fb; clr = cl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic pu, input logic po, input logic [7:0] d,
                     input logic fl, input logic fb, input logic cl);
    drive(pu, po, d, fl, fb, cl);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] wv, rv;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_data", 32'(dout), 0);

    // Fill to full, then overflow.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'h11 + 8'(i), 0, 0, 0);
      if (i == 2) chk("af_after3", 32'(afull), 0);
      if (i == 3) chk("af_after4", 32'(afull), 1);
    end
    chk("full5", 32'(full), 1);
    chk("cnt5", 32'(cnt), 5);
    cyc(1, 0, 8'h16, 0, 0, 0);
    chk("ovf6", 32'(ovf), 1);
    chk("cnt6", 32'(cnt), 5);
    chk("head6", 32'(dout), 32'h11);

    // Drain in order, then underflow and clear.
    for (int i = 0; i < 5; i++) begin
      chk("pop_data", 32'(dout), 32'h11 + i);
      cyc(0, 1, 8'h00, 0, 0, 0);
    end
    chk("cnt_drain", 32'(cnt), 0);
    cyc(0, 1, 8'h00, 0, 0, 0);
    chk("unf", 32'(unf), 1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_unf", 32'(unf), 0);

    // Wrap: occupancy held at 2..3, pointers cross 4->0.
    wv = 8'h20; rv = 8'h20;
    cyc(1, 0, wv, 0, 0, 0); wv++;
    cyc(1, 0, wv, 0, 0, 0); wv++;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 != 0) begin
        chk("wrap_data", 32'(dout), 32'(rv));
        rv++;
      end
      case (i % 3)
        0: cyc(1, 0, wv, 0, 0, 0);
        1: cyc(1, 1, wv, 0, 0, 0);
        default: cyc(0, 1, 8'h00, 0, 0, 0);
      endcase
      if (i % 3 != 2) wv++;
    end
    chk("wrap_cnt", 32'(cnt), 2);
    for (int i = 0; i < 2; i++) begin
      chk("wrap_tail", 32'(dout), 32'(rv));
      rv++;
      cyc(0, 1, 8'h00, 0, 0, 0);
    end
    chk("wrap_last", 32'(rv), 32'h2A);

    // Flush-but-first with a concurrent push.
    cyc(1, 0, 8'h31, 0, 0, 0);
    cyc(1, 0, 8'h32, 0, 0, 0);
    cyc(1, 0, 8'h33, 0, 0, 0);
    cyc(1, 0, 8'h99, 0, 1, 0);
    chk("fbf_cnt", 32'(cnt), 1);
    chk("fbf_head", 32'(dout), 32'h31);
    cyc(0, 1, 8'h00, 0, 0, 0);
    chk("fbf_pop", 32'(cnt), 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("fbf_zero", 32'(cnt), 0);

    // Full flush ignores push/pop and flags nothing.
    cyc(1, 0, 8'h61, 0, 0, 0);
    cyc(1, 0, 8'h62, 0, 0, 0);
    cyc(1, 1, 8'h63, 1, 0, 0);
    chk("flush_cnt", 32'(cnt), 0);
    cyc(0, 1, 8'h00, 1, 0, 0);
    chk("flush_unf", 32'(unf), 0);

    // Set beats clear in the same cycle.
    cyc(0, 1, 8'h00, 0, 0, 1);
    chk("set_wins", 32'(unf), 1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("clr2", 32'(unf), 0);

    // Asynchronous reset mid-cycle.
    cyc(1, 0, 8'h41, 0, 0, 0);
    cyc(1, 0, 8'h42, 0, 0, 0);
    chk("pre_rst_cnt", 32'(cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_data", 32'(dout), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", 32'(cnt), 0);
    chk("post_rst_empty", 32'(empty), 1);
    cyc(1, 0, 8'h51, 0, 0, 0);
    chk("post_rst_data", 32'(dout), 32'h51);
    chk("post_rst_cnt1", 32'(cnt), 1);
    cyc(0, 1, 8'h00, 0, 0, 0);

    // Fall-through instance: bypass on empty push+pop.
    chk("ft_idle_empty", 32'(empty_f), 1);
    drive(1, 1, 8'hA5, 0, 0, 0);
    #1;
    chk("ft_data", 32'(dout_f), 32'hA5);
    chk("ft_empty", 32'(empty_f), 0);
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    #1;
    chk("ft_cnt", 32'(cnt_f), 0);
    chk("ft_unf", 32'(unf_f), 0);
    chk("ft_ovf", 32'(ovf_f), 0);
    chk("ft_empty_after", 32'(empty_f), 1);
    drive(1, 0, 8'h5A, 0, 0, 0);
    #1;
    chk("ft_push_data", 32'(dout_f), 32'h5A);
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    #1;
    chk("ft_push_cnt", 32'(cnt_f), 1);
    chk("ft_push_head", 32'(dout_f), 32'h5A);
    cyc(0, 0, 8'h00, 0, 0, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
